// File: rtl/rvfi_bus_env_pkg.sv
// Shared types and helpers for the rvfi_bus_env formal bus environment.
package rvfi_bus_env_pkg;

    // Command-side handshake state of one channel
    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } cmdState_t;

    // Bits needed to hold the values 0..limit inclusive
    function automatic int cntWidth(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/rvfi_bus_env_chan.sv
// One independent bus channel: outstanding-response tracking, command-side
// handshake checking and optional fairness forcing.
// Optional feature: RVFI_BUS_FAIRNESS_EN bounds command and response stalls
// at MAX_STALL cycles; without it the random inputs are never overridden.
module rvfi_bus_env_chan
    import rvfi_bus_env_pkg::*;
#(
    parameter int DW         = 32,
    parameter int PEND_DEPTH = 4,
    parameter int MAX_STALL  = 3,
    parameter bit WR_RSP     = 1'b0,
    parameter int CW         = cntWidth(PEND_DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic          cmd_wr,
    output logic          cmd_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    input  logic          rnd_cmd_ready,
    input  logic          rnd_rsp_valid,
    input  logic [DW-1:0] rnd_rsp_data,
    output logic [CW-1:0] pend_count,
    output logic          protocol_err
);

    localparam logic [CW-1:0] DEPTH_C = CW'(PEND_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    // A zero-depth channel or a zero fairness bound makes no sense
    if (PEND_DEPTH < 1 || MAX_STALL < 1) begin : gBadParams
        $error("rvfi_bus_env_chan: PEND_DEPTH and MAX_STALL must be >= 1");
    end

    cmdState_t     state;
    cmdState_t     stateNext;
    logic [CW-1:0] pendCount;
    logic [CW-1:0] pendNext;
    logic          heldWr;
    logic          errSet;
    logic          notFull;
    logic          accept;
    logic          expects;
    logic          stalled;
    logic          forceCmd;
    logic          forceRsp;

    // Full blocks commands and empty blocks responses, so the counter can
    // neither overflow nor underflow. The count is registered, which gives
    // at least one cycle between an accept and its response.
    assign notFull   = (pendCount < DEPTH_C);
    assign cmd_ready = (rnd_cmd_ready | forceCmd) & notFull;
    assign rsp_valid = (rnd_rsp_valid | forceRsp) & (pendCount != '0);
    assign rsp_data  = rsp_valid ? rnd_rsp_data : '0;
    assign accept    = cmd_valid & cmd_ready;
    assign expects   = accept & (~cmd_wr | WR_RSP);
    assign stalled   = cmd_valid & ~cmd_ready;

    assign pend_count = pendCount;

`ifdef RVFI_BUS_FAIRNESS_EN
    localparam int            SW          = cntWidth(MAX_STALL);
    localparam logic [SW-1:0] STALL_MAX_C = SW'(MAX_STALL);
    localparam logic [SW-1:0] STALL_ONE_C = SW'(1);

    logic [SW-1:0] cmdStall;
    logic [SW-1:0] rspWait;

    // Count consecutive refused-command cycles and unanswered-pending cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            cmdStall <= '0;
            rspWait  <= '0;
        end else begin
            if (!stalled)
                cmdStall <= '0;
            else if (cmdStall != STALL_MAX_C)
                cmdStall <= cmdStall + STALL_ONE_C;

            if (rsp_valid || pendCount == '0)
                rspWait <= '0;
            else if (rspWait != STALL_MAX_C)
                rspWait <= rspWait + STALL_ONE_C;
        end
    end

    // The fullness gate is applied again in cmd_ready; kept here for clarity
    assign forceCmd = (cmdStall == STALL_MAX_C) & notFull;
    assign forceRsp = (rspWait == STALL_MAX_C);
`else
    assign forceCmd = 1'b0;
    assign forceRsp = 1'b0;
`endif

    // Net change of one per cycle at most; accept plus response cancels out
    always_comb begin
        pendNext = pendCount;
        if (expects && !rsp_valid)
            pendNext = pendCount + ONE_C;
        else if (!expects && rsp_valid)
            pendNext = pendCount - ONE_C;
    end

    // Next state and violation detection: a stalled command must be held
    // with the same direction until it is accepted
    always_comb begin
        stateNext = state;
        errSet    = 1'b0;
        unique case (state)
            IDLE: begin
                if (stalled)
                    stateNext = STALL;
            end
            STALL: begin
                if (!cmd_valid || cmd_wr != heldWr)
                    errSet = 1'b1;
                if (accept || !cmd_valid)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, outstanding count, captured direction and sticky error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            pendCount    <= '0;
            heldWr       <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state     <= stateNext;
            pendCount <= pendNext;
            if (state == IDLE)
                heldWr <= cmd_wr;
            if (errSet)
                protocol_err <= 1'b1;
        end
    end

endmodule

// File: rtl/rvfi_bus_env.sv
// Formal bus environment: NCH fully independent channels, each modelling a
// slave that accepts commands and returns responses under solver control.
// Optional feature: define RVFI_BUS_FAIRNESS_EN to bound stalls at MAX_STALL.
module rvfi_bus_env
    import rvfi_bus_env_pkg::*;
#(
    parameter int             NCH        = 2,
    parameter int             DW         = 32,
    parameter int             PEND_DEPTH = 4,
    parameter int             MAX_STALL  = 3,
    parameter logic [NCH-1:0] WR_RSP     = '0,
    localparam int            CW         = cntWidth(PEND_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    cmd_valid,
    input  logic [NCH-1:0]    cmd_wr,
    output logic [NCH-1:0]    cmd_ready,
    output logic [NCH-1:0]    rsp_valid,
    output logic [NCH*DW-1:0] rsp_data,
    input  logic [NCH-1:0]    rnd_cmd_ready,
    input  logic [NCH-1:0]    rnd_rsp_valid,
    input  logic [NCH*DW-1:0] rnd_rsp_data,
    output logic [NCH*CW-1:0] pend_count,
    output logic [NCH-1:0]    protocol_err
);

    // One channel per slice; no signal crosses between channels
    for (genvar c = 0; c < NCH; c++) begin : gChan
        rvfi_bus_env_chan #(
            .DW         (DW),
            .PEND_DEPTH (PEND_DEPTH),
            .MAX_STALL  (MAX_STALL),
            .WR_RSP     (WR_RSP[c]),
            .CW         (CW)
        ) uChan (
            .clock         (clock),
            .reset         (reset),
            .cmd_valid     (cmd_valid[c]),
            .cmd_wr        (cmd_wr[c]),
            .cmd_ready     (cmd_ready[c]),
            .rsp_valid     (rsp_valid[c]),
            .rsp_data      (rsp_data[c*DW +: DW]),
            .rnd_cmd_ready (rnd_cmd_ready[c]),
            .rnd_rsp_valid (rnd_rsp_valid[c]),
            .rnd_rsp_data  (rnd_rsp_data[c*DW +: DW]),
            .pend_count    (pend_count[c*CW +: CW]),
            .protocol_err  (protocol_err[c])
        );
    end

endmodule

// File: tb/tb_rvfi_bus_env.sv
// Self-checking bench for rvfi_bus_env (default parameters, WR_RSP = 2'b00).
// Directed scenarios followed by randomized traffic against a behavioural
// model; the fairness scenario runs only when RVFI_BUS_FAIRNESS_EN is defined.
module tb_rvfi_bus_env;

    localparam int NCH        = 2;
    localparam int DW         = 32;
    localparam int PEND_DEPTH = 4;
    localparam int MAX_STALL  = 3;
    localparam int CW         = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [NCH-1:0]    cmd_valid;
    logic [NCH-1:0]    cmd_wr;
    logic [NCH-1:0]    cmd_ready;
    logic [NCH-1:0]    rsp_valid;
    logic [NCH*DW-1:0] rsp_data;
    logic [NCH-1:0]    rnd_cmd_ready;
    logic [NCH-1:0]    rnd_rsp_valid;
    logic [NCH*DW-1:0] rnd_rsp_data;
    logic [NCH*CW-1:0] pend_count;
    logic [NCH-1:0]    protocol_err;

    int nTests = 0;
    int nFail  = 0;

    rvfi_bus_env #(
        .NCH        (NCH),
        .DW         (DW),
        .PEND_DEPTH (PEND_DEPTH),
        .MAX_STALL  (MAX_STALL),
        .WR_RSP     (2'b00)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_wr        (cmd_wr),
        .cmd_ready     (cmd_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rnd_cmd_ready (rnd_cmd_ready),
        .rnd_rsp_valid (rnd_rsp_valid),
        .rnd_rsp_data  (rnd_rsp_data),
        .pend_count    (pend_count),
        .protocol_err  (protocol_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pendOf(input int c);
        return 64'(pend_count[c*CW +: CW]);
    endfunction

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One reset cycle with the command side idle, then release
    task automatic doReset();
        reset     = 1'b1;
        cmd_valid = '0;
        tick();
        reset = 1'b0;
    endtask

    // Reference model state for the randomized phase
    int mPend    [NCH];
    bit mStalled [NCH];
    bit mHeld    [NCH];
    bit mErr     [NCH];

    initial begin
        int acc;
        reset         = 1'b1;
        cmd_valid     = '0;
        cmd_wr        = '0;
        rnd_cmd_ready = '0;
        rnd_rsp_valid = 2'b11;
        rnd_rsp_data  = 64'h1234_5678_9ABC_DEF0;
        tick();
        tick();
        #1;
        // Reset state: nothing pending, no responses even with rnd_rsp_valid high
        check("rst_pend", 64'(pend_count), 64'(0));
        check("rst_err", 64'(protocol_err), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        rnd_rsp_valid = '0;
        reset = 1'b0;
        tick();

`ifndef RVFI_BUS_FAIRNESS_EN
        // Five reads into a depth-4 channel: four accepted, then full
        rnd_cmd_ready = 2'b11;
        cmd_valid     = 2'b01;
        cmd_wr        = 2'b00;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (cmd_ready[0]) acc++;
            if (i == 4) begin
                check("full_cmd_ready", 64'(cmd_ready[0]), 64'(0));
                check("full_pend", pendOf(0), 64'(4));
            end
            tick();
        end
        check("full_accepts", 64'(acc), 64'(4));
        rnd_rsp_valid = 2'b01;
        doReset();
        #1;
        check("full_reset_pend", pendOf(0), 64'(0));
        check("full_reset_rsp_valid", 64'(rsp_valid[0]), 64'(0));
        rnd_rsp_valid = '0;

        // Simultaneous accept and response keep the count at 2
        cmd_valid = 2'b01;
        tick();
        tick();
        #1;
        check("same_cycle_pend_before", pendOf(0), 64'(2));
        rnd_rsp_valid = 2'b01;
        #1;
        check("same_cycle_cmd_ready", 64'(cmd_ready[0]), 64'(1));
        check("same_cycle_rsp_valid", 64'(rsp_valid[0]), 64'(1));
        check("same_cycle_rsp_data", 64'(rsp_data[DW-1:0]), 64'(rnd_rsp_data[DW-1:0]));
        tick();
        cmd_valid     = '0;
        rnd_rsp_valid = '0;
        #1;
        check("same_cycle_pend_after", pendOf(0), 64'(2));
        check("same_cycle_no_err", 64'(protocol_err), 64'(0));

        // Write on ch1 without write responses: accepted, never answered
        doReset();
        cmd_valid     = 2'b10;
        cmd_wr        = 2'b10;
        rnd_cmd_ready = 2'b10;
        rnd_rsp_valid = 2'b10;
        #1;
        check("wr_ch1_cmd_ready", 64'(cmd_ready[1]), 64'(1));
        tick();
        cmd_valid = '0;
        cmd_wr    = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wr_ch1_pend", pendOf(1), 64'(0));
            check("wr_ch1_rsp_valid", 64'(rsp_valid[1]), 64'(0));
            tick();
        end

        // Dropping cmd_valid while stalled raises a sticky error
        doReset();
        rnd_cmd_ready = '0;
        rnd_rsp_valid = '0;
        cmd_valid     = 2'b01;
        tick();
        #1;
        check("stall_err_clean", 64'(protocol_err[0]), 64'(0));
        tick();
        cmd_valid = 2'b00;
        tick();
        cmd_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_err_sticky", 64'(protocol_err[0]), 64'(1));
            check("stall_err_ch1_clean", 64'(protocol_err[1]), 64'(0));
            tick();
        end
        doReset();
        #1;
        check("stall_err_cleared", 64'(protocol_err[0]), 64'(0));

        // Reset with three outstanding discards them
        rnd_cmd_ready = 2'b01;
        cmd_valid     = 2'b01;
        tick();
        tick();
        tick();
        cmd_valid = '0;
        #1;
        check("midrst_pend_before", pendOf(0), 64'(3));
        reset         = 1'b1;
        rnd_rsp_valid = 2'b01;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("midrst_pend", pendOf(0), 64'(0));
            check("midrst_rsp_valid", 64'(rsp_valid[0]), 64'(0));
            tick();
        end

        // Randomized traffic against the behavioural model
        doReset();
        for (int c = 0; c < NCH; c++) begin
            mPend[c] = 0; mStalled[c] = 1'b0; mHeld[c] = 1'b0; mErr[c] = 1'b0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset = ((cyc % 150) == 149);
            for (int c = 0; c < NCH; c++) begin
                if (!(mStalled[c] && ($urandom_range(19) != 0))) begin
                    cmd_valid[c] = 1'($urandom_range(1));
                    cmd_wr[c]    = 1'($urandom_range(1));
                end
            end
            rnd_cmd_ready = 2'($urandom_range(3));
            rnd_rsp_valid = 2'($urandom_range(3));
            rnd_rsp_data  = {$urandom, $urandom};
            #1;
            for (int c = 0; c < NCH; c++) begin
                logic expReady, expRv, acc1;
                logic [DW-1:0] expData;
                expReady = rnd_cmd_ready[c] && (mPend[c] < PEND_DEPTH);
                expRv    = rnd_rsp_valid[c] && (mPend[c] != 0);
                expData  = expRv ? rnd_rsp_data[c*DW +: DW] : '0;
                check($sformatf("rand_c%0d_cmd_ready", c), 64'(cmd_ready[c]), 64'(expReady));
                check($sformatf("rand_c%0d_rsp_valid", c), 64'(rsp_valid[c]), 64'(expRv));
                check($sformatf("rand_c%0d_rsp_data", c), 64'(rsp_data[c*DW +: DW]), 64'(expData));
                check($sformatf("rand_c%0d_pend", c), pendOf(c), 64'(mPend[c]));
                check($sformatf("rand_c%0d_err", c), 64'(protocol_err[c]), 64'(mErr[c]));
                acc1 = cmd_valid[c] && expReady;
                if (reset) begin
                    mPend[c] = 0; mStalled[c] = 1'b0; mErr[c] = 1'b0;
                end else begin
                    mPend[c] = mPend[c] + ((acc1 && !cmd_wr[c]) ? 1 : 0) - (expRv ? 1 : 0);
                    if (mStalled[c] && (!cmd_valid[c] || cmd_wr[c] != mHeld[c]))
                        mErr[c] = 1'b1;
                    mStalled[c] = cmd_valid[c] && !expReady;
                    mHeld[c]    = cmd_wr[c];
                end
            end
            tick();
        end
        reset = 1'b0;
`else
        // All random inputs low: the read is forced in at cycle 3 and its
        // response is forced out four cycles after that
        doReset();
        rnd_cmd_ready = '0;
        rnd_rsp_valid = '0;
        rnd_rsp_data  = 64'h0BAD_F00D_CAFE_BABE;
        cmd_valid     = 2'b01;
        cmd_wr        = 2'b00;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fair_cmd_ready_c%0d", i), 64'(cmd_ready[0]), 64'(i == 3));
            tick();
        end
        cmd_valid = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fair_rsp_valid_c%0d", i + 4), 64'(rsp_valid[0]), 64'(i == 3));
            if (i == 3)
                check("fair_rsp_data", 64'(rsp_data[DW-1:0]), 64'(32'hCAFE_BABE));
            tick();
        end
        #1;
        check("fair_pend_drained", pendOf(0), 64'(0));
        check("fair_no_err", 64'(protocol_err), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
